// File: rtl/jtbubl_sdram_pkg.sv
// Shared types and constants for the Bubble Bobble SDRAM read scheduler.
//   NSLOT      number of requesters sharing the SDRAM read port
//   SDRAM_AW   width of the 16-bit-word SDRAM address
//   slot_idx_t index of a requester slot
//   state_t    scheduler FSM state
package jtbubl_sdram_pkg;

  localparam int NSLOT    = 5;
  localparam int SDRAM_AW = 22;

  typedef logic [2:0] slot_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

endpackage

// File: rtl/jtbubl_sdram_slot.sv
// One requester slot: a one-entry read cache plus address translation.
//   clk, rstn     system clock, async active-low reset
//   cs, addr      read request from the requester
//   grant         scheduler picked this slot; latch addr as the request address
//   fill          SDRAM data for this slot's request is on data_read
//   clr           drop the cached entry (download or loop reset)
//   data_read     SDRAM read data
//   ok, dout      cached data valid for the current addr / cached data
//   pending       request present and not served by the cache
//   sdram_addr    16-bit-word SDRAM address for the current addr
// DW = 8 selects a byte slot (byte picked by addr[0]); DW = 32 a word slot.
import jtbubl_sdram_pkg::*;

module jtbubl_sdram_slot #(
  parameter int                  AW     = 18,
  parameter int                  DW     = 8,
  parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  input  logic                grant,
  input  logic                fill,
  input  logic                clr,
  input  logic [31:0]         data_read,
  output logic                ok,
  output logic [DW-1:0]       dout,
  output logic                pending,
  output logic [SDRAM_AW-1:0] sdram_addr
);

  logic [AW-1:0] cache_addr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] cache_data;
  logic [DW-1:0] fill_data;
  logic          valid;
  logic          hit;

  assign hit     = valid && (cache_addr == addr);
  assign ok      = cs && hit;
  assign pending = cs && !hit;
  assign dout    = cache_data;

  generate
    if (DW == 8) begin : g_byte
      wire unused_hi = ^data_read[31:16];
      // byte lane follows the address that was actually requested, not the
      // current one, since the requester may have moved on
      assign fill_data  = req_addr[0] ? data_read[15:8] : data_read[7:0];
      assign sdram_addr = OFFSET + SDRAM_AW'(addr[AW-1:1]);
    end else begin : g_word
      assign fill_data  = data_read[DW-1:0];
      assign sdram_addr = OFFSET + SDRAM_AW'({addr, 1'b0});
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cache_addr <= '0;
      req_addr   <= '0;
      cache_data <= '0;
      valid      <= 1'b0;
    end else begin
      if (grant) req_addr <= addr;
      // an in-flight fill survives a concurrent flush
      if (fill) begin
        cache_addr <= req_addr;
        cache_data <= fill_data;
        valid      <= 1'b1;
      end else if (clr) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtbubl_sdram_sched.sv
// Five-requester SDRAM read scheduler (main, sub, MCU, sound, GFX).
//   clk, rstn                 system clock, async active-low reset
//   downloading               ROM download: blocks scheduling, flushes caches
//   loop_rst                  synchronous cache flush
//   slotN_cs/addr/ok/dout     requester ports, N = 0..4 (slot4 = 32-bit GFX)
//   sdram_req/addr/ack        request handshake to the SDRAM controller
//   data_rdy, data_read       read data return
//   refresh_en                controller may refresh (idle, nothing pending)
// Build option: JTBUBL_SDRAM_RR_EN selects round-robin arbitration;
// otherwise fixed priority slot4 > slot0 > slot1 > slot2 > slot3.
//
// state | meaning
// IDLE  | arbitrate among pending slots, launch a request
// REQ   | sdram_req/sdram_addr held until sdram_ack
// WAIT  | accepted, waiting for data_rdy to fill the granted slot
import jtbubl_sdram_pkg::*;

module jtbubl_sdram_sched #(
  parameter int                  SLOT0_AW     = 18,
  parameter int                  SLOT1_AW     = 15,
  parameter int                  SLOT2_AW     = 12,
  parameter int                  SLOT3_AW     = 15,
  parameter int                  SLOT4_AW     = 18,
  parameter logic [SDRAM_AW-1:0] SLOT0_OFFSET = 22'h0,
  parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'h1_4000,
  parameter logic [SDRAM_AW-1:0] SLOT2_OFFSET = 22'h1_C000,
  parameter logic [SDRAM_AW-1:0] SLOT3_OFFSET = 22'h1_8000,
  parameter logic [SDRAM_AW-1:0] SLOT4_OFFSET = 22'h2_0000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic                slot0_cs,
  input  logic                slot1_cs,
  input  logic                slot2_cs,
  input  logic                slot3_cs,
  input  logic                slot4_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  input  logic [SLOT3_AW-1:0] slot3_addr,
  input  logic [SLOT4_AW-1:0] slot4_addr,
  output logic                slot0_ok,
  output logic                slot1_ok,
  output logic                slot2_ok,
  output logic                slot3_ok,
  output logic                slot4_ok,
  output logic [7:0]          slot0_dout,
  output logic [7:0]          slot1_dout,
  output logic [7:0]          slot2_dout,
  output logic [7:0]          slot3_dout,
  output logic [31:0]         slot4_dout,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic                refresh_en
);

  state_t              st, st_nxt;
  slot_idx_t           gnt, gnt_nxt, win;
  logic                req_nxt;
  logic [SDRAM_AW-1:0] addr_nxt;
  logic                grant, fill, clr;
  logic [NSLOT-1:0]    pending, grant_v, fill_v;
  logic [SDRAM_AW-1:0] slot_sa [NSLOT];

  assign clr = downloading || loop_rst;

  jtbubl_sdram_slot #(.AW(SLOT0_AW), .DW(8), .OFFSET(SLOT0_OFFSET)) u_slot0 (
    .clk, .rstn, .cs(slot0_cs), .addr(slot0_addr), .grant(grant_v[0]), .fill(fill_v[0]),
    .clr, .data_read, .ok(slot0_ok), .dout(slot0_dout), .pending(pending[0]),
    .sdram_addr(slot_sa[0]));
  jtbubl_sdram_slot #(.AW(SLOT1_AW), .DW(8), .OFFSET(SLOT1_OFFSET)) u_slot1 (
    .clk, .rstn, .cs(slot1_cs), .addr(slot1_addr), .grant(grant_v[1]), .fill(fill_v[1]),
    .clr, .data_read, .ok(slot1_ok), .dout(slot1_dout), .pending(pending[1]),
    .sdram_addr(slot_sa[1]));
  jtbubl_sdram_slot #(.AW(SLOT2_AW), .DW(8), .OFFSET(SLOT2_OFFSET)) u_slot2 (
    .clk, .rstn, .cs(slot2_cs), .addr(slot2_addr), .grant(grant_v[2]), .fill(fill_v[2]),
    .clr, .data_read, .ok(slot2_ok), .dout(slot2_dout), .pending(pending[2]),
    .sdram_addr(slot_sa[2]));
  jtbubl_sdram_slot #(.AW(SLOT3_AW), .DW(8), .OFFSET(SLOT3_OFFSET)) u_slot3 (
    .clk, .rstn, .cs(slot3_cs), .addr(slot3_addr), .grant(grant_v[3]), .fill(fill_v[3]),
    .clr, .data_read, .ok(slot3_ok), .dout(slot3_dout), .pending(pending[3]),
    .sdram_addr(slot_sa[3]));
  jtbubl_sdram_slot #(.AW(SLOT4_AW), .DW(32), .OFFSET(SLOT4_OFFSET)) u_slot4 (
    .clk, .rstn, .cs(slot4_cs), .addr(slot4_addr), .grant(grant_v[4]), .fill(fill_v[4]),
    .clr, .data_read, .ok(slot4_ok), .dout(slot4_dout), .pending(pending[4]),
    .sdram_addr(slot_sa[4]));

`ifdef JTBUBL_SDRAM_RR_EN
  slot_idx_t rr;

  // scan from the farthest slot towards rr+1 so the nearest pending one wins
  always_comb begin
    win = rr;
    for (int k = NSLOT; k >= 1; k--) begin
      if (pending[slot_idx_t'((int'(rr) + k) % NSLOT)])
        win = slot_idx_t'((int'(rr) + k) % NSLOT);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rr <= '0;
    else if (grant) rr <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      if (pending[k]) win = slot_idx_t'(k);
    end
    if (pending[4]) win = 3'd4;
  end
`endif

  always_comb begin
    st_nxt   = st;
    gnt_nxt  = gnt;
    req_nxt  = sdram_req;
    addr_nxt = sdram_addr;
    grant    = 1'b0;
    fill     = 1'b0;
    if (downloading) begin
      st_nxt  = IDLE;
      req_nxt = 1'b0;
    end else begin
      unique case (st)
        IDLE: if (|pending) begin
          grant    = 1'b1;
          gnt_nxt  = win;
          addr_nxt = slot_sa[win];
          req_nxt  = 1'b1;
          st_nxt   = REQ;
        end
        REQ: if (sdram_ack) begin
          req_nxt = 1'b0;
          if (data_rdy) begin
            fill   = 1'b1;
            st_nxt = IDLE;
          end else begin
            st_nxt = WAIT;
          end
        end
        WAIT: if (data_rdy) begin
          fill   = 1'b1;
          st_nxt = IDLE;
        end
        default: st_nxt = IDLE;
      endcase
    end
    for (int i = 0; i < NSLOT; i++) begin
      grant_v[i] = grant && (win == slot_idx_t'(i));
      fill_v[i]  = fill && (gnt == slot_idx_t'(i));
    end
  end

  assign refresh_en = (st == IDLE) && !downloading && !(|pending);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= IDLE;
      gnt        <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      st         <= st_nxt;
      gnt        <= gnt_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_jtbubl_sdram_sched.sv
module tb_jtbubl_sdram_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = '0;
  logic [4:0]  cs = '0;
  logic [17:0] sa [5];
  wire  [4:0]  ok;
  wire  [7:0]  d0, d1, d2, d3;
  wire  [31:0] d4;
  wire         sdram_req, refresh_en;
  wire  [21:0] sdram_addr;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  jtbubl_sdram_sched dut (
    .clk(clk), .rstn(rstn), .downloading(downloading), .loop_rst(loop_rst),
    .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]), .slot4_cs(cs[4]),
    .slot0_addr(sa[0]), .slot1_addr(sa[1][14:0]), .slot2_addr(sa[2][11:0]),
    .slot3_addr(sa[3][14:0]), .slot4_addr(sa[4]),
    .slot0_ok(ok[0]), .slot1_ok(ok[1]), .slot2_ok(ok[2]), .slot3_ok(ok[3]), .slot4_ok(ok[4]),
    .slot0_dout(d0), .slot1_dout(d1), .slot2_dout(d2), .slot3_dout(d3), .slot4_dout(d4),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en));

  typedef struct {
    int          slot;
    logic [17:0] addr;
    logic [31:0] dr;
    logic [21:0] exp_sa;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] dout_of(input int s);
    case (s)
      0: return {24'd0, d0};
      1: return {24'd0, d1};
      2: return {24'd0, d2};
      3: return {24'd0, d3};
      default: return d4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Waits (bounded) for sdram_req, checks latency and address, then acks and
  // returns data. Returns on the negedge where the fill should be visible.
  task automatic serve(input string nm, input logic [21:0] exp_sa,
                       input logic [31:0] dr, input bit same_cycle);
    int n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_sa"}, {10'd0, sdram_addr}, {10'd0, exp_sa});
    sdram_ack = 1'b1;
    if (same_cycle) begin
      data_rdy  = 1'b1;
      data_read = dr;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    if (!same_cycle) begin
      chk({nm, "_req_drop"}, {31'd0, sdram_req}, 0);
      data_rdy  = 1'b1;
      data_read = dr;
      @(negedge clk);
    end
    data_rdy = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_req"}, {31'd0, sdram_req}, 1);
  endtask

  logic [21:0] ord_sa [3];
  logic [31:0] ord_dr [3];

  initial begin
    for (int i = 0; i < 5; i++) sa[i] = '0;
    vecs[0] = '{0, 18'h00003,  32'h0000_AB12, 22'h000001, 32'h0000_00AB};
    vecs[1] = '{4, 18'h00010,  32'hDEAD_BEEF, 22'h020020, 32'hDEAD_BEEF};
    vecs[2] = '{1, 18'h000A4,  32'h1234_5678, 22'h014052, 32'h0000_0078};
    vecs[3] = '{2, 18'h00FFF,  32'h0000_C3A5, 22'h01C7FF, 32'h0000_00C3};
    vecs[4] = '{3, 18'h07FFE,  32'h0000_9911, 22'h01BFFF, 32'h0000_0011};
    vecs[5] = '{4, 18'h3FFFF,  32'h0102_0304, 22'h09FFFE, 32'h0102_0304};
    vecs[6] = '{0, 18'h3FFFE,  32'h0000_5A66, 22'h01FFFF, 32'h0000_0066};

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, sdram_req}, 0);
    chk("rst_sa", {10'd0, sdram_addr}, 0);
    chk("rst_ok", {27'd0, ok}, 0);
    chk("rst_dout", {d0 | d1 | d2 | d3, 8'd0} | d4, 0);
    chk("rst_refresh", {31'd0, refresh_en}, 1);
    @(negedge clk);
    rstn = 1'b1;

    // table: miss, fill, then hit with no new request
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cs[vecs[i].slot] = 1'b1;
      sa[vecs[i].slot] = vecs[i].addr;
      #1 chk($sformatf("v%0d_miss", i), {31'd0, ok[vecs[i].slot]}, 0);
      serve($sformatf("v%0d", i), vecs[i].exp_sa, vecs[i].dr, (i % 2) == 1);
      chk($sformatf("v%0d_ok", i), {31'd0, ok[vecs[i].slot]}, 1);
      chk($sformatf("v%0d_dout", i), dout_of(vecs[i].slot), vecs[i].exp_dout);
      @(negedge clk);
      chk($sformatf("v%0d_hit", i), {31'd0, ok[vecs[i].slot]}, 1);
      chk($sformatf("v%0d_noreq", i), {31'd0, sdram_req}, 0);
      chk($sformatf("v%0d_refresh", i), {31'd0, refresh_en}, 1);
      cs[vecs[i].slot] = 1'b0;
    end

    // three simultaneous misses; last grant was slot0
`ifdef JTBUBL_SDRAM_RR_EN
    ord_sa = '{22'h014100, 22'h020080, 22'h000080};
    ord_dr = '{32'h0000_0022, 32'hCAFE_0044, 32'h0000_0011};
`else
    ord_sa = '{22'h020080, 22'h000080, 22'h014100};
    ord_dr = '{32'hCAFE_0044, 32'h0000_0011, 32'h0000_0022};
`endif
    @(negedge clk);
    cs[0] = 1'b1; sa[0] = 18'h00100;
    cs[1] = 1'b1; sa[1] = 18'h00200;
    cs[4] = 1'b1; sa[4] = 18'h00040;
    #1 chk("arb_refresh_off", {31'd0, refresh_en}, 0);
    for (int g = 0; g < 3; g++) serve($sformatf("arb%0d", g), ord_sa[g], ord_dr[g], 1'b1);
    chk("arb_ok", {29'd0, ok[4], ok[1], ok[0]}, 3'b111);
    chk("arb_d0", {24'd0, d0}, 32'h11);
    chk("arb_d1", {24'd0, d1}, 32'h22);
    chk("arb_d4", d4, 32'hCAFE_0044);
    cs[1] = 1'b0;
    cs[4] = 1'b0;
    cs[0] = 1'b0;

    // slot2 moves its address while its access is in WAIT
    @(negedge clk);
    cs[2] = 1'b1; sa[2] = 18'h00010;
    wait_req("mv");
    chk("mv_sa1", {10'd0, sdram_addr}, 32'h01C008);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    sa[2] = 18'h00020;
    #1 chk("mv_ok_wait", {31'd0, ok[2]}, 0);
    data_rdy = 1'b1; data_read = 32'h0000_0077;
    @(negedge clk);
    data_rdy = 1'b0;
    chk("mv_ok_after", {31'd0, ok[2]}, 0);
    @(negedge clk);
    chk("mv_req2", {31'd0, sdram_req}, 1);
    chk("mv_sa2", {10'd0, sdram_addr}, 32'h01C010);
    sa[2] = 18'h00010;
    #1 chk("mv_old_ok", {31'd0, ok[2]}, 1);
    chk("mv_old_dout", {24'd0, d2}, 32'h77);
    sa[2] = 18'h00020;
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h0000_0055;
    @(negedge clk);
    sdram_ack = 1'b0; data_rdy = 1'b0;
    chk("mv_new_ok", {31'd0, ok[2]}, 1);
    chk("mv_new_dout", {24'd0, d2}, 32'h55);
    cs[2] = 1'b0;

    // downloading during REQ abandons the access and flushes caches
    @(negedge clk);
    cs[0] = 1'b1; sa[0] = 18'h00100;
    cs[3] = 1'b1; sa[3] = 18'h00010;
    #1 chk("dl_pre_hit", {31'd0, ok[0]}, 1);
    wait_req("dl");
    chk("dl_sa", {10'd0, sdram_addr}, 32'h018008);
    downloading = 1'b1;
    @(negedge clk);
    chk("dl_req", {31'd0, sdram_req}, 0);
    chk("dl_refresh", {31'd0, refresh_en}, 0);
    chk("dl_ok", {27'd0, ok}, 0);
    downloading = 1'b0;
    serve("dl_re0", 22'h000080, 32'h0000_00C4, 1'b0);
    chk("dl_re0_ok", {31'd0, ok[0]}, 1);
    chk("dl_re0_dout", {24'd0, d0}, 32'hC4);
    serve("dl_re3", 22'h018008, 32'h0000_0033, 1'b1);
    chk("dl_re3_dout", {24'd0, d3}, 32'h33);
    cs[3] = 1'b0;

    // loop_rst flushes; a fill in flight during loop_rst still sets valid
    @(negedge clk);
    loop_rst = 1'b1;
    @(negedge clk);
    loop_rst = 1'b0;
    chk("lr_flush", {31'd0, ok[0]}, 0);
    wait_req("lr");
    chk("lr_sa", {10'd0, sdram_addr}, 32'h000080);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    loop_rst = 1'b1;
    @(negedge clk);
    loop_rst = 1'b0;
    data_rdy = 1'b1; data_read = 32'h0000_005D;
    @(negedge clk);
    data_rdy = 1'b0;
    chk("lr_fill_ok", {31'd0, ok[0]}, 1);
    chk("lr_fill_dout", {24'd0, d0}, 32'h5D);
    cs[0] = 1'b0;

    // reset pulse while in WAIT; the late data_rdy must be ignored
    @(negedge clk);
    cs[1] = 1'b1; sa[1] = 18'h00300;
    wait_req("rw");
    chk("rw_sa", {10'd0, sdram_addr}, 32'h014180);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rstn = 1'b0;
    cs[1] = 1'b0;
    #1;
    chk("rw_req", {31'd0, sdram_req}, 0);
    chk("rw_refresh", {31'd0, refresh_en}, 1);
    chk("rw_d0", {24'd0, d0}, 0);
    @(negedge clk);
    rstn = 1'b1;
    data_rdy = 1'b1; data_read = 32'h0000_00EE;
    @(negedge clk);
    data_rdy = 1'b0;
    chk("rw_req_after", {31'd0, sdram_req}, 0);
    chk("rw_refresh_after", {31'd0, refresh_en}, 1);
    cs[1] = 1'b1;
    #1 chk("rw_no_fill", {31'd0, ok[1]}, 0);
    @(negedge clk);
    cs[1] = 1'b0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
